// File: rtl/rvm_shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rvm_shift_ctrl_pkg : shift op codes, controller state encodings, helpers
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package rvm_shift_ctrl_pkg;

  localparam logic [1:0] RVM_SHIFT_NOP  = 2'd0;
  localparam logic [1:0] RVM_SHIFT_SLL  = 2'd1;
  localparam logic [1:0] RVM_SHIFT_SRL  = 2'd2;
  localparam logic [1:0] RVM_SHIFT_ASR  = 2'd3;

  localparam logic [1:0] RVM_SHCTL_IDLE = 2'd0;
  localparam logic [1:0] RVM_SHCTL_EXEC = 2'd1;
  localparam logic [1:0] RVM_SHCTL_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = RVM_SHCTL_IDLE,
    ST_EXEC = RVM_SHCTL_EXEC,
    ST_RESP = RVM_SHCTL_RESP
  } shctl_state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] lhs;
    logic [4:0]  rhs;
  } shift_req_t;

  // Returns the index of the requester to grant; only meaningful if v0|v1.
  function automatic logic pick_grant(input logic v0, input logic v1,
                                      input logic last, input logic rr);
    logic g;
    if (v0 && v1) g = rr ? ~last : 1'b0;
    else          g = v1;
    return g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvm_shift_ctrl_shift.sv
// -----------------------------------------------------------------------------
// rvm_shift : 32-bit combinational shifter (NOP yields zero)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rvm_shift
  import rvm_shift_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] lhs,
  input  logic [4:0]  rhs,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      RVM_SHIFT_SLL: result = lhs << rhs;
      RVM_SHIFT_SRL: result = lhs >> rhs;
      RVM_SHIFT_ASR: result = $unsigned($signed(lhs) >>> rhs);
      default:       result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rvm_shift_ctrl.sv
// -----------------------------------------------------------------------------
// rvm_shift_ctrl : two-requester arbiter and sequencer around one rvm_shift
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rvm_shift_ctrl
  import rvm_shift_ctrl_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_lhs,
  input  logic [4:0]  req0_rhs,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_lhs,
  input  logic [4:0]  req1_rhs,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        busy
);

  shctl_state_e state_q, state_d;
  shift_req_t   req_q, req_d;
  logic         owner_q, owner_d;
  logic         last_grant_q, last_grant_d;
  logic [31:0]  resp_q, resp_d;

  logic         grant;
  logic         idle_accept;
  logic [1:0]   dp_op;
  logic [31:0]  dp_result;

  assign grant       = pick_grant(req0_valid, req1_valid, last_grant_q, RR);
  assign idle_accept = !reset && (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = idle_accept && !grant;
  assign req1_ready  = idle_accept &&  grant;

  // The shifter only sees live operands while executing.
  assign dp_op = (state_q == ST_EXEC) ? req_q.op : RVM_SHIFT_NOP;

  rvm_shift u_shift (
    .op     (dp_op),
    .lhs    (req_q.lhs),
    .rhs    (req_q.rhs),
    .result (dp_result)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    resp_d       = resp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          req_d        = grant ? '{op: req1_op, lhs: req1_lhs, rhs: req1_rhs}
                               : '{op: req0_op, lhs: req0_lhs, rhs: req0_rhs};
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_d  = dp_result;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      resp_q       <= resp_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp0_data  = resp_q;
  assign rsp1_data  = resp_q;

endmodule

`default_nettype wire

// File: tb/tb_rvm_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rvm_shift_ctrl : scoreboard bench for rvm_shift_ctrl (RR=1 and RR=0)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_rvm_shift_ctrl;
  import rvm_shift_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic [1:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_lhs = 0, req1_lhs = 0;
  logic [4:0]  req0_rhs = 0, req1_rhs = 0;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  wire         req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  wire  [31:0] rsp0_data, rsp1_data;

  logic        fp_valid = 1'b1;
  wire         fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
  wire  [31:0] fp_rsp0_data, fp_rsp1_data;
  int          fp_grants = 0;

  typedef struct {
    int          owner;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rvm_shift_ctrl #(.RR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_lhs(req0_lhs), .req0_rhs(req0_rhs),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_lhs(req1_lhs), .req1_rhs(req1_rhs),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  rvm_shift_ctrl #(.RR(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(fp_valid), .req0_ready(fp_req0_ready), .req0_op(RVM_SHIFT_SLL),
    .req0_lhs(32'h1), .req0_rhs(5'd1),
    .req1_valid(fp_valid), .req1_ready(fp_req1_ready), .req1_op(RVM_SHIFT_SRL),
    .req1_lhs(32'h100), .req1_rhs(5'd1),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(1'b1), .rsp0_data(fp_rsp0_data),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(1'b1), .rsp1_data(fp_rsp1_data),
    .busy(fp_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [4:0] s);
    case (op)
      RVM_SHIFT_SLL: return a << s;
      RVM_SHIFT_SRL: return a >> s;
      RVM_SHIFT_ASR: return $unsigned($signed(a) >>> s);
      default:       return 32'h0;
    endcase
  endfunction

  function automatic logic rsp_v(input int n);
    return (n == 1) ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [31:0] rsp_d(input int n);
    return (n == 1) ? rsp1_data : rsp0_data;
  endfunction

  task automatic drive_req(input int n, input logic v, input logic [1:0] op,
                           input logic [31:0] lhs, input logic [4:0] rhs);
    if (n == 1) begin
      req1_valid = v; req1_op = op; req1_lhs = lhs; req1_rhs = rhs;
    end else begin
      req0_valid = v; req0_op = op; req0_lhs = lhs; req0_rhs = rhs;
    end
  endtask

  task automatic set_rsp_ready(input int n, input logic v);
    if (n == 1) rsp1_ready = v;
    else        rsp0_ready = v;
  endtask

  task automatic pop_check(input int n, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      check("rsp_unexpected", 32'(n), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check("rsp_owner", 32'(n), 32'(e.owner));
      check("rsp_data", data, e.data);
    end
  endtask

  // Scoreboard consumer: every response handshake must match the oldest entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid && rsp0_ready) pop_check(0, rsp0_data);
      if (rsp1_valid && rsp1_ready) pop_check(1, rsp1_data);
    end
  end

  always @(negedge clk) begin
    if (!reset && (fp_req0_ready || fp_req1_ready)) begin
      fp_grants++;
      check("fp_grant", {31'd0, fp_req1_ready}, 32'd0);
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input int n, input logic [1:0] op, input logic [31:0] lhs,
                        input logic [4:0] rhs, input int hold);
    logic        got;
    logic [31:0] held;
    int          other;
    other = 1 - n;
    drive_req(n, 1'b1, op, lhs, rhs);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (n == 1) ? req1_ready : req0_ready;
    end
    check("accept", {31'd0, got}, 32'd1);
    sb.push_back('{owner: n, data: model(op, lhs, rhs)});
    @(posedge clk); #1;
    drive_req(n, 1'b0, RVM_SHIFT_NOP, 32'h0, 5'd0);
    @(negedge clk);
    check("exec_busy", {31'd0, busy}, 32'd1);
    check("exec_rsp_valid", {31'd0, rsp_v(n)}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("latency_rsp_valid", {31'd0, rsp_v(n)}, 32'd1);
    held = rsp_d(n);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      drive_req(other, 1'b1, RVM_SHIFT_SLL, 32'h1, 5'd1);
      @(negedge clk);
      check("hold_data", rsp_d(n), held);
      check("hold_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
      check("hold_busy", {31'd0, busy}, 32'd1);
      check("hold_rsp_valid", {31'd0, rsp_v(n)}, 32'd1);
    end
    @(posedge clk); #1;
    drive_req(other, 1'b0, RVM_SHIFT_NOP, 32'h0, 5'd0);
    set_rsp_ready(n, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(n, 1'b0);
    @(negedge clk);
    check("done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got;
    logic g;
    logic exp_g;

    // Reset state: readies gated off even with a valid present.
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_rsp0_data", rsp0_data, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b0;

    // Round-robin contention starting straight out of reset.
    drive_req(0, 1'b1, RVM_SHIFT_SLL, 32'h3, 5'd4);
    drive_req(1, 1'b1, RVM_SHIFT_SRL, 32'hF0, 5'd4);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    exp_g = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      g   = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = req0_ready | req1_ready;
        g   = req1_ready;
      end
      check("rr_accept", {31'd0, got}, 32'd1);
      if (!got) break;
      check("rr_grant", {31'd0, g}, {31'd0, exp_g});
      sb.push_back('{owner: int'(g), data: g ? 32'h0000_000F : 32'h0000_0030});
      exp_g = ~exp_g;
      @(posedge clk); #1;
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("rr_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Directed operations, including shift-amount boundaries and NOP.
    run_op(0, RVM_SHIFT_SLL, 32'h0000_0001, 5'd31, 0);
    run_op(1, RVM_SHIFT_ASR, 32'h8000_0000, 5'd4, 0);
    run_op(1, RVM_SHIFT_SRL, 32'h8000_0000, 5'd4, 0);
    run_op(0, RVM_SHIFT_NOP, 32'hFFFF_FFFF, 5'd3, 0);
    run_op(1, RVM_SHIFT_ASR, 32'h8000_0000, 5'd31, 0);
    run_op(0, RVM_SHIFT_SLL, 32'hDEAD_BEEF, 5'd0, 0);
    run_op(0, RVM_SHIFT_SRL, 32'h1234_5678, 5'd8, 5);

    // Reset while executing: the in-flight operation must vanish.
    drive_req(0, 1'b1, RVM_SHIFT_SLL, 32'h1, 5'd31);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req0_ready;
    end
    check("rstx_accept", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, RVM_SHIFT_NOP, 32'h0, 5'd0);
    reset = 1'b1;
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstx_busy", {31'd0, busy}, 32'd0);
    check("rstx_rsp0_data", rsp0_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rstx_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    run_op(0, RVM_SHIFT_SLL, 32'h0000_0001, 5'd31, 0);

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    check("fp_grants_seen", {31'd0, (fp_grants >= 4)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rvm_shift_ctrl.md
RVM_SHIFT_CTRL -- requirements
Module: rvm_shift_ctrl

Interface
REQ-001 SHALL have parameter: RR  default 1  1 = round-robin grant between requesters, 0 = fixed priority to requester 0.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports (N = 0,1): reqN_valid  input  1  requester N presents a shift.
REQ-005 SHALL have ports: reqN_ready  output  1  controller accepts requester N's shift this cycle.
REQ-006 SHALL have ports: reqN_op  input  2  shift op, RVM_SHIFT_NOP/SLL/SRL/ASR encoding.
REQ-007 SHALL have ports: reqN_lhs  input  32  value to shift.
REQ-008 SHALL have ports: reqN_rhs  input  5  shift amount.
REQ-009 SHALL have ports: rspN_valid  output  1  result for requester N is available.
REQ-010 SHALL have ports: rspN_ready  input  1  requester N consumes the result.
REQ-011 SHALL have ports: rspN_data  output  32  shift result.
REQ-012 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-014 SHALL, in IDLE with any reqN_valid high, assert reqN_ready for exactly one granted requester, combinationally from the valids and the grant pointer.
REQ-015 SHALL, with RR=1 and both valid, grant the requester other than last_grant; with one valid, grant that one.
REQ-016 SHALL, with RR=0, always grant requester 0 when both are valid.
REQ-017 SHALL, on reqN_valid & reqN_ready, latch op, lhs, rhs and owner = N, update last_grant = N, and enter EXEC.
REQ-018 SHALL hold both reqN_ready low in EXEC and RESP; requesters hold valid and operands stable until ready.
REQ-019 SHALL drive the shift datapath op as NOP in IDLE and RESP, and with the latched op/lhs/rhs in EXEC.
REQ-020 SHALL, in EXEC, register datapath result[31:0] into the response register and enter RESP on the next edge.
REQ-021 SHALL accept requests with op = NOP, and return rspN_data = 0.
REQ-022 SHALL, in RESP, assert rspN_valid only for the owner, with rspN_data held stable until rspN_ready.
REQ-023 SHALL, on the owner's rsp handshake, return to IDLE; no request is accepted in that same cycle.
REQ-024 SHALL have latency: request accepted at edge T, rsp_valid high from cycle T+2; minimum 3 cycles per operation.
REQ-025 SHALL ignore the non-owner's rspN_ready and any reqN_valid changes while not in IDLE.
REQ-026 SHALL compute SLL as lhs << rhs, SRL as a zero-fill right shift, and ASR as a sign-fill right shift, each over 32 bits and using rhs[4:0] only.

Reset
REQ-027 SHALL, on reset, enter IDLE, clear the latched operands, response register and owner, and set last_grant = 1 so requester 0 wins the first contention.
REQ-028 SHALL drive all outputs low during and after reset until a new request: reqN_ready is low while reset is high, rspN_valid = 0, rspN_data = 0, busy = 0.
REQ-029 SHALL discard any in-flight operation on reset asserted in EXEC or RESP, with no response issued.

Structure
REQ-030 SHALL take RVM_SHIFT_NOP/SLL/SRL/ASR from rvm_constants.v and add RVM_SHCTL_IDLE/EXEC/RESP state encodings there.
REQ-031 SHALL instantiate exactly one rvm_shift as its sole sub-module and contain no other shifter.
REQ-032 SHALL contain only the FSM, grant pointer, operand latches and response register.

Verification
REQ-033 SHALL cover: req0 SLL lhs=0x0000_0001 rhs=31 -> rsp0_data=0x8000_0000, rsp0_valid exactly 2 cycles after accept.
REQ-034 SHALL cover: req1 ASR lhs=0x8000_0000 rhs=4 -> 0xF800_0000; req1 SRL same operands -> 0x0800_0000.
REQ-035 SHALL cover: both valid from reset, RR=1 -> grants in order 0,1,0,1; with RR=0 -> grant 0 every time.
REQ-036 SHALL cover: rsp0_ready held low 5 cycles -> rsp0_data stable, req0_ready and req1_ready low, busy=1 throughout.
REQ-037 SHALL cover: reset asserted in EXEC -> next cycle IDLE, busy=0, no rspN_valid, next request served normally.
REQ-038 SHALL cover: NOP request lhs=0xFFFF_FFFF rhs=3 -> rsp_data=0x0000_0000.
